// File: rtl/conv_pe_pkg.sv
// conv_pe_pkg: shared states, default parameters and output scaling for the conv window PE
package conv_pe_pkg;
  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;
  localparam int DEF_DW = 16;
  localparam int DEF_K = 5;
  localparam int DEF_FRAC = 8;
  localparam int DEF_MAX_W = 32;
  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] acc, input int frac, input int dw);
    logic signed [63:0] s, hi, lo;
    s = acc >>> frac;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return (s > hi) ? hi : (s < lo) ? lo : s;
  endfunction
endpackage

// File: rtl/conv_line_buf.sv
// conv_line_buf: K-1 row buffers feeding a KxK window shift register, flattened row-major
module conv_line_buf import conv_pe_pkg::*; #(
  parameter int DW = DEF_DW,
  parameter int K = DEF_K,
  parameter int MAX_W = DEF_MAX_W,
  parameter int AW = $clog2(MAX_W)
) (
  input  logic                clk,
  input  logic                shift_en,
  input  logic [AW-1:0]       col,
  input  logic [DW-1:0]       din,
  output logic [K*K*DW-1:0]   win
);
  logic [DW-1:0] lb [K-1][MAX_W];
  logic [DW-1:0] w [K][K];
  logic [DW-1:0] v [K];
  // v[0] is the current row, v[K-1] the oldest buffered row at this column
  always_comb begin
    v[0] = din;
    for (int i = 1; i < K; i++) v[i] = lb[i-1][col];
  end
  always_ff @(posedge clk)
    if (shift_en) begin
      for (int i = 0; i < K - 1; i++) lb[i][col] <= v[i];
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) w[r][c] <= w[r][c+1];
        w[r][K-1] <= v[K-1-r];
      end
    end
  for (genvar r = 0; r < K; r++) begin : g_r
    for (genvar c = 0; c < K; c++) begin : g_c
      assign win[(r*K+c)*DW +: DW] = w[r][c];
    end
  end
endmodule

// File: rtl/conv_window_pe.sv
// conv_window_pe: streaming KxK convolution PE with weight load, backpressure, saturation and ReLU
module conv_window_pe import conv_pe_pkg::*; #(
  parameter int DW = DEF_DW,
  parameter int K = DEF_K,
  parameter int MAX_W = DEF_MAX_W,
  parameter int FRAC = DEF_FRAC,
  parameter int ACCW = 2 * DW + 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [5:0]    fmap_w,
  input  logic          keep_w,
  input  logic          relu_en,
  input  logic [DW-1:0] w_data,
  input  logic          w_valid,
  output logic          w_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy,
  output logic          done,
  output logic          err
);
  localparam int AW = $clog2(MAX_W);
  localparam int N = K * K;
  localparam int WCW = $clog2(N);
  localparam logic [5:0] KM1 = 6'(K - 1);
  localparam logic [5:0] KW = 6'(K);
  localparam logic [5:0] MW = 6'(MAX_W);
  state_t state, state_n;
  logic [5:0] fw, row, col;
  logic relu_q;
  logic [WCW-1:0] wcnt;
  logic signed [DW-1:0] w [N];
  logic [N*DW-1:0] win;
  logic signed [2*DW-1:0] prod [N];
  logic signed [ACCW-1:0] acc, sum_q;
  logic signed [DW-1:0] sat, res;
  logic v1, v2, v3, l1, l2, l3;
  logic stall, accept, w_acc, fw_ok, last_px;
  assign stall = out_valid && !out_ready;
  assign in_ready = state == STREAM && !stall;
  assign w_ready = state == LOAD_W;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign accept = in_valid && in_ready;
  assign w_acc = w_valid && w_ready;
  assign fw_ok = fmap_w >= KW && fmap_w <= MW;
  assign last_px = row == fw - 6'd1 && col == fw - 6'd1;
  conv_line_buf #(.DW(DW), .K(K), .MAX_W(MAX_W), .AW(AW)) u_lb (
    .clk(clk), .shift_en(accept), .col(col[AW-1:0]), .din(in_data), .win(win)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start && fw_ok) state_n = keep_w ? STREAM : LOAD_W;
      LOAD_W:  if (w_acc && wcnt == WCW'(N - 1)) state_n = STREAM;
      STREAM:  if (accept && last_px) state_n = DRAIN;
      DRAIN:   if (out_valid && out_ready && out_last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    acc = '0;
    for (int i = 0; i < N; i++) acc = acc + ACCW'(prod[i]);
    sat = DW'(sat_shift(64'(sum_q), FRAC, DW));
    res = (relu_q && sat[DW-1]) ? '0 : sat;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      err <= 1'b0;
      fw <= '0;
      relu_q <= 1'b0;
      row <= '0;
      col <= '0;
      wcnt <= '0;
      {v1, v2, v3, l1, l2, l3} <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      out_data <= '0;
    end else begin
      state <= state_n;
      err <= state == IDLE && start && !fw_ok;
      if (state == IDLE && start) begin
        fw <= fmap_w;
        relu_q <= relu_en;
        row <= '0;
        col <= '0;
        wcnt <= '0;
      end
      if (w_acc) wcnt <= wcnt + 1'b1;
      if (accept) begin
        col <= (col == fw - 6'd1) ? 6'd0 : col + 6'd1;
        row <= (col == fw - 6'd1) ? row + 6'd1 : row;
      end
      // the whole pipeline freezes while the output is held
      if (!stall) begin
        v1 <= accept && row >= KM1 && col >= KM1;
        l1 <= accept && last_px;
        v2 <= v1;
        l2 <= l1;
        v3 <= v2;
        l3 <= l2;
        out_valid <= v3;
        out_last <= l3;
        out_data <= res;
      end
    end
  always_ff @(posedge clk) begin
    if (w_acc) w[wcnt] <= w_data;
    if (!stall) begin
      for (int i = 0; i < N; i++) prod[i] <= (2*DW)'(w[i]) * (2*DW)'($signed(win[i*DW +: DW]));
      sum_q <= acc;
    end
  end
endmodule

// File: tb/tb_conv_window_pe.sv
// tb_conv_window_pe: randomized scoreboard bench for conv_window_pe against a plain-arithmetic convolution model
module tb_conv_window_pe;
  localparam int K = 5;
  typedef struct { logic [15:0] d; logic l; } exp_t;
  logic clk = 0, rst = 1, start = 0, keep_w = 0, relu_en = 0;
  logic [5:0] fmap_w = 0;
  logic [15:0] w_data = 0, in_data = 0, out_data;
  logic w_valid = 0, in_valid = 0, out_ready = 1;
  logic w_ready, in_ready, out_valid, out_last, busy, done, err;
  int checks = 0, errors = 0;
  int wk [K*K];
  int px [1024];
  exp_t exp_q [$];
  int rmode = 0;
  bit gaps = 0, keep_frame = 0, stalled_prev = 0, last_prev = 0;
  logic [15:0] held;

  conv_window_pe dut (
    .clk(clk), .rst(rst), .start(start), .fmap_w(fmap_w), .keep_w(keep_w), .relu_en(relu_en),
    .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string nm, input longint act, input longint expv);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic int s16(input int v);
    logic signed [15:0] t;
    t = 16'(v);
    return int'(t);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference: valid correlation, floor divide by 2^8, clamp to int16, optional ReLU
  task automatic model(input int fw, input bit relu);
    for (int i = 0; i <= fw - K; i++)
      for (int j = 0; j <= fw - K; j++) begin
        longint s = 0, q;
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++) s += longint'(wk[r*K+c]) * longint'(px[(i+r)*fw + j + c]);
        q = s / 256;
        if (s < 0 && s % 256 != 0) q = q - 1;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        if (relu && q < 0) q = 0;
        exp_q.push_back('{16'(q), (i == fw - K && j == fw - K)});
      end
  endtask

  task automatic send_w(input int d);
    int t = 0;
    bit hs;
    w_data = 16'(d);
    w_valid = 1;
    do begin
      @(negedge clk);
      hs = w_ready;
      tick();
      t++;
    end while (!hs && t < 1000);
    chk(hs, "w_handshake", hs, 1);
    w_valid = 0;
  endtask

  task automatic send_px(input int d);
    int t = 0;
    bit hs;
    in_data = 16'(d);
    in_valid = 1;
    do begin
      @(negedge clk);
      hs = in_ready;
      tick();
      t++;
    end while (!hs && t < 1000);
    chk(hs, "px_handshake", hs, 1);
    in_valid = 0;
  endtask

  task automatic run_frame(input int fw, input bit keep, input bit relu, input int abort_at);
    int t = 0;
    model(fw, relu);
    tick();
    start = 1;
    fmap_w = 6'(fw);
    keep_w = keep;
    relu_en = relu;
    keep_frame = keep;
    tick();
    start = 0;
    if (!keep) for (int i = 0; i < K*K; i++) send_w(wk[i]);
    for (int i = 0; i < fw*fw; i++) begin
      if (i == abort_at) begin
        rst = 1;
        in_valid = 0;
        @(negedge clk);
        chk(!out_valid, "abort_out_valid", out_valid, 0);
        chk(!busy, "abort_busy", busy, 0);
        exp_q.delete();
        keep_frame = 0;
        tick();
        rst = 0;
        return;
      end
      if (gaps && $urandom_range(3) == 0) repeat ($urandom_range(1, 3)) tick();
      send_px(px[i]);
    end
    do begin
      @(negedge clk);
      t++;
    end while (!done && t < 20000);
    chk(done, "frame_done", done, 1);
    chk(exp_q.size() == 0, "outputs_left", exp_q.size(), 0);
    exp_q.delete();
    keep_frame = 0;
  endtask

  task automatic bad_start(input int fw);
    tick();
    start = 1;
    fmap_w = 6'(fw);
    tick();
    start = 0;
    @(negedge clk);
    chk(err, "err_pulse", err, 1);
    chk(!busy, "err_busy", busy, 0);
    @(negedge clk);
    chk(!err, "err_one_cycle", err, 0);
    chk(!busy, "err_busy_after", busy, 0);
  endtask

  task automatic fill_const(input int wv, input int pv);
    for (int i = 0; i < K*K; i++) wk[i] = s16(wv);
    for (int i = 0; i < 1024; i++) px[i] = s16(pv);
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < K*K; i++) wk[i] = (i == 12) ? 256 : 0;
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++) px[r*28+c] = s16((r*28 + c) << 8);
  endtask

  initial begin
    out_ready = 1;
    forever begin
      tick();
      out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ~out_ready : 1'($urandom_range(1));
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stalled_prev = 0;
      last_prev = 0;
    end else begin
      if (last_prev) chk(done, "done_after_last", done, 1);
      last_prev = 0;
      if (stalled_prev) chk(out_valid && out_data == held, "stall_hold", out_data, held);
      stalled_prev = out_valid && !out_ready;
      if (stalled_prev) begin
        held = out_data;
        chk(!in_ready, "in_ready_stall", in_ready, 0);
      end
      if (keep_frame) chk(!w_ready, "keep_w_ready", w_ready, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk(0, "unexpected_out", out_data, 0);
        else begin
          e = exp_q.pop_front();
          chk(out_data == e.d && out_last == e.l, "out_data", longint'({out_last, out_data}), longint'({e.l, e.d}));
          last_prev = out_last;
        end
      end
    end
  end

  initial begin
    repeat (3) tick();
    rst = 0;
    @(negedge clk);
    chk(!out_valid, "rst_out_valid", out_valid, 0);
    chk(out_data == 0, "rst_out_data", out_data, 0);
    chk(!out_last, "rst_out_last", out_last, 0);
    chk(!busy, "rst_busy", busy, 0);
    chk(!done, "rst_done", done, 0);
    chk(!err, "rst_err", err, 0);
    chk(!w_ready, "rst_w_ready", w_ready, 0);
    chk(!in_ready, "rst_in_ready", in_ready, 0);
    fill_const(32'h0100, 32'h0100);
    run_frame(5, 0, 0, -1);
    fill_const(32'h7FFF, 32'h7FFF);
    run_frame(5, 0, 0, -1);
    fill_const(32'h8001, 32'h7FFF);
    run_frame(5, 0, 0, -1);
    run_frame(5, 1, 1, -1);
    fill_ramp();
    run_frame(28, 0, 0, -1);
    rmode = 1;
    gaps = 1;
    run_frame(28, 1, 0, -1);
    bad_start(4);
    bad_start(33);
    rmode = 2;
    for (int f = 0; f < 3; f++) begin
      int fw = $urandom_range(5, 32);
      for (int i = 0; i < K*K; i++) wk[i] = int'($urandom_range(1023)) - 512;
      for (int i = 0; i < fw*fw; i++) px[i] = int'($urandom_range(2047)) - 1024;
      run_frame(fw, 0, 1'($urandom_range(1)), -1);
    end
    rmode = 0;
    gaps = 0;
    fill_ramp();
    run_frame(28, 0, 0, 300);
    fill_const(32'h0100, 32'h0100);
    run_frame(5, 0, 0, -1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
